plic_gateway: RTL
=================

Name: plic_gateway

Overview:
- Per-source interrupt gateway for the PLIC. Sits upstream of the PLIC register block and target/arbiter logic.
- Synchronises external interrupt lines and converts them into pending bits. Gates each source so only one request is outstanding until the handler signals completion.
- Consumes claim_req / complete_req / complete_idx from the register block and the per-target claim IDs. Produces irq_pending, which is read back through the pending register and fed to the targets.

Parameters:
- PLIC_SOURCE_COUNT, 2, number of interrupt sources; source ID n (1..COUNT) maps to bit n-1; ID 0 means "no interrupt".
- PLIC_TARGET_COUNT, 2, number of targets (claim/complete ports).
- PLIC_SOURCE_WIDTH, 2, width of a source ID; must hold PLIC_SOURCE_COUNT.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- irq_src_i  in  PLIC_SOURCE_COUNT  raw asynchronous interrupt lines, active-high
- claim_req_i  in  PLIC_TARGET_COUNT  per-target claim strobe (claim register read)
- claim_idx_i  in  PLIC_TARGET_COUNT x PLIC_SOURCE_WIDTH  ID presented to each target at claim time
- complete_req_i  in  PLIC_TARGET_COUNT  per-target completion strobe (claim register write)
- complete_idx_i  in  PLIC_TARGET_COUNT x PLIC_SOURCE_WIDTH  ID written on completion
- irq_pending_o  out  PLIC_SOURCE_COUNT  per-source pending bit (registered)

Behaviour:
- Reset (rst_n low at a clk edge): sync flops cleared, all FSMs to IDLE, edge counters cleared, irq_pending_o = 0. Reset mid-service discards in-service state; no completion is needed afterwards.
- Synchroniser: 2-flop per source. Rising irq_src_i sampled at edge k appears in sync output after edge k+1.
- Per-source FSM has three states:
  - IDLE -> PENDING when request is present (level mode: sync high).
  - PENDING -> IN_SERVICE when any claim_req_i[t]=1 with claim_idx_i[t]==n. Pending clears at that edge.
  - IN_SERVICE -> IDLE when any complete_req_i[t]=1 with complete_idx_i[t]==n.
- irq_pending_o[n-1] = (state==PENDING), registered.
- Latency: irq_src_i rising before edge 1 gives irq_pending_o high after edge 3. Claim at edge c gives pending low after c.
- After completion at edge d, with the level still high: IDLE at d, PENDING after d+1 (one-cycle gap required).
- Source-level drop while PENDING: pending stays set (PLIC semantics; no retraction).
- IN_SERVICE ignores the source level. No re-pend until complete.
- Claims and completes with ID 0 or ID > PLIC_SOURCE_COUNT are ignored.
- Complete for a source not IN_SERVICE is ignored. Claim for a source not PENDING is ignored.
- Multiple targets claiming the same ID in one cycle: a single transition occurs. Duplicate strobes are harmless.
- Claim and complete for different sources in the same cycle are handled independently in that cycle.
- Claim strobes are single-cycle; the register block guarantees one strobe per bus access.

Optional Feature:
- Macro: PLIC_EDGE_TRIG_EN.
- Defined: each source is edge-triggered.
  - A rising edge of the synced signal increments a 2-bit saturating counter (max 3; further edges dropped).
  - IDLE -> PENDING when counter>0, decrementing it on that transition.
  - Edge and decrement in the same cycle: counter unchanged.
  - After completion, remaining counts re-pend with the same one-cycle gap.
- Undefined: pure level-triggered; counters and edge detectors are not synthesised.

Test Plan:
- Reset with irq_src_i=2'b11 held -> irq_pending_o=0 during reset. irq_pending_o=2'b11 exactly 3 edges after rst_n rises.
- Source 1 high; claim_req_i[0]=1, claim_idx_i[0]=1 -> pending[0]=0 next cycle. Stays 0 for 20 cycles with the source still high.
- complete_req_i[1]=1, complete_idx_i[1]=1 while source 1 is in service and high -> pending[0]=0 for one cycle, then 1.
- Complete with ID 2 while source 2 is IDLE, and claims with ID 0 or ID 3 -> no change on irq_pending_o.
- Both targets claim ID 2 in the same cycle while target 0 completes ID 1 -> source 2 IN_SERVICE, source 1 IDLE, pending=2'b00.
- (PLIC_EDGE_TRIG_EN) 5 pulses on source 1 while in service, then 4 complete/claim cycles -> exactly 3 re-pends. The 4th complete leaves pending[0]=0.

Source files
------------

// File: rtl/plic_gateway.sv
// ---------------------------------------------------------------------------
// plic_gateway
//
// Per-source interrupt gateway for the PLIC. Each raw interrupt line passes
// through a two-flop synchroniser. A small per-source FSM (IDLE / PENDING /
// IN_SERVICE) then turns it into a pending bit. Only one request per source
// can be outstanding until the handler completes it.
//
// Configuration macro: PLIC_EDGE_TRIG_EN
//   undefined : level-triggered. IDLE -> PENDING whenever the synced line is high.
//   defined   : edge-triggered. Rising edges of the synced line are counted in
//               a 2-bit saturating counter, and each IDLE -> PENDING transition
//               consumes one count.
//
// Ports:
//   clk             clock
//   rst_n           synchronous, active-low reset
//   irq_src_i       raw asynchronous interrupt lines, active-high
//   claim_req_i     per-target claim strobe
//   claim_idx_i     per-target source ID being claimed
//   complete_req_i  per-target completion strobe
//   complete_idx_i  per-target source ID being completed
//   irq_pending_o   per-source pending bit (registered)
//
// Source ID n (1..PLIC_SOURCE_COUNT) maps to bit n-1. ID 0 and IDs beyond
// the source count never match a source, so they are ignored.
// ---------------------------------------------------------------------------
module plic_gateway #(
  parameter int PLIC_SOURCE_COUNT = 2,
  parameter int PLIC_TARGET_COUNT = 2,
  parameter int PLIC_SOURCE_WIDTH = 2
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic [PLIC_SOURCE_COUNT-1:0]                          irq_src_i,
  input  logic [PLIC_TARGET_COUNT-1:0]                          claim_req_i,
  input  logic [PLIC_TARGET_COUNT-1:0][PLIC_SOURCE_WIDTH-1:0]   claim_idx_i,
  input  logic [PLIC_TARGET_COUNT-1:0]                          complete_req_i,
  input  logic [PLIC_TARGET_COUNT-1:0][PLIC_SOURCE_WIDTH-1:0]   complete_idx_i,
  output logic [PLIC_SOURCE_COUNT-1:0]                          irq_pending_o
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PENDING    = 2'd1,
    IN_SERVICE = 2'd2
  } gw_state_e;

  // Two-flop synchroniser, shared vector for all sources.
  logic [PLIC_SOURCE_COUNT-1:0] sync_meta;
  logic [PLIC_SOURCE_COUNT-1:0] sync_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= irq_src_i;
      sync_out  <= sync_meta;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PLIC_SOURCE_COUNT; gi++) begin : g_src
      localparam logic [PLIC_SOURCE_WIDTH-1:0] SRC_ID = PLIC_SOURCE_WIDTH'(gi + 1);

      gw_state_e state;
      gw_state_e state_next;
      logic      claim_hit;
      logic      complete_hit;
      logic      request;
      logic      pending_reg;
      logic      pending_next;

      // Any target may claim or complete this source. Duplicate strobes for
      // the same ID collapse into a single hit.
      always_comb begin
        claim_hit    = 1'b0;
        complete_hit = 1'b0;
        for (int t = 0; t < PLIC_TARGET_COUNT; t++) begin
          if (claim_req_i[t] && (claim_idx_i[t] == SRC_ID)) begin
            claim_hit = 1'b1;
          end
          if (complete_req_i[t] && (complete_idx_i[t] == SRC_ID)) begin
            complete_hit = 1'b1;
          end
        end
      end

`ifdef PLIC_EDGE_TRIG_EN
      logic       sync_prev;
      logic [1:0] edge_cnt;
      logic       rise;
      logic       take;

      assign rise    = sync_out[gi] & ~sync_prev;
      assign request = (edge_cnt != 2'd0);
      // One count is consumed exactly when IDLE moves to PENDING.
      assign take    = (state == IDLE) && request;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync_prev <= 1'b0;
          edge_cnt  <= 2'd0;
        end else begin
          sync_prev <= sync_out[gi];
          // An edge and a consume in the same cycle cancel out.
          // Edges arriving at saturation are dropped.
          case ({rise, take})
            2'b10:   if (edge_cnt != 2'd3) edge_cnt <= edge_cnt + 2'd1;
            2'b01:   edge_cnt <= edge_cnt - 2'd1;
            default: edge_cnt <= edge_cnt;
          endcase
        end
      end
`else
      assign request = sync_out[gi];
`endif

      // State register. The pending flop is loaded from the next state, so
      // it tracks state==PENDING with no extra cycle of latency.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state       <= IDLE;
          pending_reg <= 1'b0;
        end else begin
          state       <= state_next;
          pending_reg <= pending_next;
        end
      end

      // Next-state logic. Once in service, the source level is ignored until
      // completion. The return to IDLE costs one cycle before re-pending.
      always_comb begin
        state_next = state;
        case (state)
          IDLE:       if (request)      state_next = PENDING;
          PENDING:    if (claim_hit)    state_next = IN_SERVICE;
          IN_SERVICE: if (complete_hit) state_next = IDLE;
          default:                      state_next = IDLE;
        endcase
      end

      // Output decode.
      always_comb begin
        pending_next = (state_next == PENDING);
      end

      assign irq_pending_o[gi] = pending_reg;
    end
  endgenerate

endmodule
